// File: rtl/fnd_scan_decoder.sv
// fnd_scan_decoder: samples a 4-digit multiplexed 7-segment bus (seg/com, both
// active-low) and rebuilds the displayed 16-bit value and decimal points.
// Latency: 2-cycle input sync + SETTLE_CYCLES dwell + 1 cycle to value/frame_pulse.
// Backpressure: none; free-running monitor, outputs are level/strobe only.
//
// Ports:
//   clk, reset_p   : clock, asynchronous active-high reset
//   seg_in[7:0]    : {dp,g,f,e,d,c,b,a}, 0 = lit
//   com_in[3:0]    : digit enables, 0 = selected; com[0] = rightmost digit
//   value[15:0]    : confirmed display value, nibble i from digit i
//   dp[3:0]        : confirmed decimal points, 1 = lit
//   value_valid    : value holds a frame seen STABLE_FRAMES times in a row
//   frame_pulse    : one-cycle strobe per completed frame
//   decode_err     : strobe alongside frame_pulse when the frame held a bad pattern
//   link_lost      : no digit captured for TIMEOUT_CYCLES
module fnd_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int STABLE_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic [7:0]  seg_in,
  input  logic [3:0]  com_in,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic        value_valid,
  output logic        frame_pulse,
  output logic        decode_err,
  output logic        link_lost
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int FW = $clog2(STABLE_FRAMES + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [FW-1:0] STABLE_FULL  = FW'(STABLE_FRAMES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  // Two-stage synchronizer on the whole {com,seg} bus.
  logic [11:0]   sync1;
  logic [11:0]   sync2;

  logic [SW-1:0] settle_cnt;
  logic          captured;
  logic [3:0]    mask;
  logic          err_flag;
  logic [15:0]   nib;
  logic [3:0]    dp_tmp;
  logic [15:0]   cand_val;
  logic [3:0]    cand_dp;
  logic [FW-1:0] stable_cnt;
  logic [TW-1:0] tmo_cnt;

  logic [3:0]    com_s;
  logic [7:0]    seg_s;
  assign {com_s, seg_s} = sync2;

  logic one_cold;
  assign one_cold = ($countones(~com_s) == 1);

  logic [1:0] dig_idx;
  always_comb begin
    dig_idx = 2'd0;
    case (com_s)
      4'b1110: dig_idx = 2'd0;
      4'b1101: dig_idx = 2'd1;
      4'b1011: dig_idx = 2'd2;
      4'b0111: dig_idx = 2'd3;
      default: dig_idx = 2'd0;
    endcase
  end

  // Active-low gfedcba to hex; anything else (including blank) decodes to 0.
  logic [3:0] dec_nib;
  logic       dec_ok;
  always_comb begin
    dec_nib = 4'h0;
    dec_ok  = 1'b1;
    case (seg_s[6:0])
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      default: begin
        dec_nib = 4'h0;
        dec_ok  = 1'b0;
      end
    endcase
  end

  // settle_cnt counts cycles the current synchronized value has been held,
  // minus one, so reaching SETTLE_LAST means SETTLE_CYCLES stable cycles.
  logic       do_capture;
  logic [3:0] mask_next;
  logic       frame_done;
  logic       err_next;
  assign do_capture = one_cold && !captured && (settle_cnt >= SETTLE_LAST);
  assign mask_next  = mask | (4'b0001 << dig_idx);
  assign frame_done = do_capture && (mask_next == 4'hF);
  assign err_next   = err_flag | ~dec_ok;

  // Frame as it stands including the digit being captured this cycle, so the
  // completing capture can load value in the same edge that raises frame_pulse.
  logic [15:0] asm_val;
  logic [3:0]  asm_dp;
  always_comb begin
    asm_val                        = nib;
    asm_dp                         = dp_tmp;
    asm_val[{dig_idx, 2'b00} +: 4] = dec_nib;
    asm_dp[dig_idx]                = ~seg_s[7];
  end

  logic [FW-1:0] stable_next;
  always_comb begin
    stable_next = stable_cnt;
    if (err_next)
      stable_next = '0;
    else if ({asm_val, asm_dp} == {cand_val, cand_dp})
      stable_next = (stable_cnt >= STABLE_FULL) ? STABLE_FULL : stable_cnt + FW'(1);
    else
      stable_next = FW'(1);
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      sync1       <= '1;
      sync2       <= '1;
      settle_cnt  <= '0;
      captured    <= 1'b0;
      mask        <= '0;
      err_flag    <= 1'b0;
      nib         <= '0;
      dp_tmp      <= '0;
      cand_val    <= '0;
      cand_dp     <= '0;
      stable_cnt  <= '0;
      tmo_cnt     <= '0;
      value       <= '0;
      dp          <= '0;
      value_valid <= 1'b0;
      frame_pulse <= 1'b0;
      decode_err  <= 1'b0;
      link_lost   <= 1'b0;
    end else begin
      sync1       <= {com_in, seg_in};
      sync2       <= sync1;
      frame_pulse <= 1'b0;
      decode_err  <= 1'b0;

      if (do_capture) begin
        captured  <= 1'b1;
        tmo_cnt   <= '0;
        link_lost <= 1'b0;
        nib       <= asm_val;
        dp_tmp    <= asm_dp;
        if (frame_done) begin
          mask        <= '0;
          err_flag    <= 1'b0;
          frame_pulse <= 1'b1;
          decode_err  <= err_next;
          cand_val    <= asm_val;
          cand_dp     <= asm_dp;
          stable_cnt  <= stable_next;
          if (!err_next && stable_next == STABLE_FULL) begin
            value       <= asm_val;
            dp          <= asm_dp;
            value_valid <= 1'b1;
          end
        end else begin
          mask     <= mask_next;
          err_flag <= err_next;
        end
      end else if (tmo_cnt == TIMEOUT_LAST) begin
        // Counter parks here so link_lost holds until the next capture.
        link_lost   <= 1'b1;
        value_valid <= 1'b0;
        mask        <= '0;
        err_flag    <= 1'b0;
        stable_cnt  <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end

      // A change in the bus starts a new dwell; this overrides the capture
      // flag set above because the next value belongs to a different dwell.
      if (sync1 != sync2) begin
        settle_cnt <= '0;
        captured   <= 1'b0;
      end else if (settle_cnt != SETTLE_LAST) begin
        settle_cnt <= settle_cnt + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_decoder.sv
module tb_fnd_scan_decoder;

  localparam int SETTLE  = 4;
  localparam int STABLE  = 2;
  localparam int TIMEOUT = 1000;

  logic        clk = 1'b0;
  logic        reset_p;
  logic [7:0]  seg_in;
  logic [3:0]  com_in;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        value_valid;
  logic        frame_pulse;
  logic        decode_err;
  logic        link_lost;

  fnd_scan_decoder #(
    .SETTLE_CYCLES (SETTLE),
    .STABLE_FRAMES (STABLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .seg_in     (seg_in),
    .com_in     (com_in),
    .value      (value),
    .dp         (dp),
    .value_valid(value_valid),
    .frame_pulse(frame_pulse),
    .decode_err (decode_err),
    .link_lost  (link_lost)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_fp  = 0;
  int n_err = 0;

  logic [6:0] code_tab [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30)
        $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Works on the raw input samples: a digit is taken once the same {com,seg}
  // has been sampled SETTLE times in a row, and shows up two edges later
  // because of the input synchronizer.
  logic [15:0] e_val;
  logic [3:0]  e_dp;
  logic        e_vv, e_fp, e_err, e_ll;
  logic [3:0]  m_nib [4];
  logic [3:0]  m_dpa;
  logic [3:0]  m_mask;
  logic        m_err;
  int          m_scnt;
  logic [19:0] m_cand;
  int          gap;
  logic [11:0] prev_s;
  int          run_len;
  logic        d1_vld, d2_vld, cap;
  logic [11:0] d1_dat, d2_dat, cx, xs;
  int          idx;
  logic        found;
  logic [3:0]  nibv;
  logic [19:0] frame;

  task automatic model_reset();
    e_val = '0; e_dp = '0; e_vv = 0; e_fp = 0; e_err = 0; e_ll = 0;
    for (int i = 0; i < 4; i++) m_nib[i] = '0;
    m_dpa = '0; m_mask = '0; m_err = 0; m_scnt = 0; m_cand = '0; gap = 0;
    prev_s = 12'hFFF; run_len = 1;
    d1_vld = 0; d2_vld = 0; d1_dat = '0; d2_dat = '0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (reset_p) begin
        model_reset();
      end else begin
        cap    = d2_vld;
        cx     = d2_dat;
        d2_vld = d1_vld;
        d2_dat = d1_dat;
        xs     = {com_in, seg_in};
        if (xs == prev_s) run_len++;
        else run_len = 1;
        prev_s = xs;
        d1_vld = (run_len == SETTLE) && ($countones(~xs[11:8]) == 1);
        d1_dat = xs;
        e_fp  = 0;
        e_err = 0;
        if (cap) begin
          gap  = 0;
          e_ll = 0;
          idx  = 0;
          for (int i = 0; i < 4; i++) if (!cx[8+i]) idx = i;
          found = 0;
          nibv  = 0;
          for (int i = 0; i < 16; i++)
            if (code_tab[i] == cx[6:0]) begin found = 1; nibv = i[3:0]; end
          if (!found) m_err = 1;
          m_nib[idx] = nibv;
          m_dpa[idx] = ~cx[7];
          m_mask[idx] = 1'b1;
          if (m_mask == 4'hF) begin
            frame = {m_nib[3], m_nib[2], m_nib[1], m_nib[0], m_dpa};
            e_fp  = 1;
            e_err = m_err;
            if (m_err) m_scnt = 0;
            else if (frame == m_cand) m_scnt = (m_scnt + 1 > STABLE) ? STABLE : m_scnt + 1;
            else m_scnt = 1;
            m_cand = frame;
            if (!m_err && m_scnt == STABLE) begin
              e_val = frame[19:4];
              e_dp  = frame[3:0];
              e_vv  = 1;
            end
            m_mask = '0;
            m_err  = 0;
          end
        end else begin
          gap++;
          if (gap >= TIMEOUT) begin
            e_ll = 1; e_vv = 0; m_mask = '0; m_err = 0; m_scnt = 0;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (reset_p) begin
        chk("rst_outputs", {value, dp, value_valid, frame_pulse, decode_err, link_lost}, 32'h0);
      end else begin
        chk("value", value, e_val);
        chk("dp", dp, e_dp);
        chk("value_valid", value_valid, e_vv);
        chk("frame_pulse", frame_pulse, e_fp);
        chk("decode_err", decode_err, e_err);
        chk("link_lost", link_lost, e_ll);
        if (frame_pulse) n_fp++;
        if (decode_err) n_err++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [3:0] c, input logic [7:0] s, input int n);
    com_in = c;
    seg_in = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [15:0] v, input logic [3:0] dpm, input logic [3:0] blank,
                      input int glitch);
    for (int d = 3; d >= 0; d--) begin
      logic [7:0] s;
      s = {~dpm[d], code_tab[v[d*4 +: 4]]};
      if (blank[d]) s = {~dpm[d], 7'h7F};
      if (glitch > 0) drive(~(4'b0001 << d), 8'h00, glitch);
      drive(~(4'b0001 << d), s, 50 - glitch);
    end
  endtask

  initial begin
    code_tab[0]  = 7'h40; code_tab[1]  = 7'h79; code_tab[2]  = 7'h24; code_tab[3]  = 7'h30;
    code_tab[4]  = 7'h19; code_tab[5]  = 7'h12; code_tab[6]  = 7'h02; code_tab[7]  = 7'h78;
    code_tab[8]  = 7'h00; code_tab[9]  = 7'h10; code_tab[10] = 7'h08; code_tab[11] = 7'h03;
    code_tab[12] = 7'h46; code_tab[13] = 7'h21; code_tab[14] = 7'h06; code_tab[15] = 7'h0E;

    reset_p = 1'b1;
    com_in  = 4'hF;
    seg_in  = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {value, dp, value_valid, frame_pulse, decode_err, link_lost}, 32'h0);
    reset_p = 1'b0;

    // 1: two identical frames of 1234
    scan(16'h1234, 4'b0000, 4'b0000, 0);
    chk("t1_frames_after_1", n_fp, 1);
    chk("t1_valid_after_1", value_valid, 1'b0);
    scan(16'h1234, 4'b0000, 4'b0000, 0);
    chk("t1_frames_after_2", n_fp, 2);
    chk("t1_value", value, 16'h1234);
    chk("t1_valid", value_valid, 1'b1);
    chk("t1_model_value", e_val, 16'h1234);

    // 2: ghost pattern for 2 cycles at every digit change
    scan(16'h1234, 4'b0000, 4'b0000, 2);
    scan(16'h1234, 4'b0000, 4'b0000, 2);
    chk("t2_frames", n_fp, 4);
    chk("t2_value", value, 16'h1234);
    chk("t2_no_err", n_err, 0);

    // 3: blank digit 1
    scan(16'h1234, 4'b0000, 4'b0010, 0);
    chk("t3_err_count", n_err, 1);
    chk("t3_value_kept", value, 16'h1234);
    chk("t3_valid_kept", value_valid, 1'b1);
    chk("t3_model_err", m_scnt, 0);

    // 4: 59.59 with the point on digit 2
    scan(16'h5959, 4'b0100, 4'b0000, 0);
    chk("t4_value_first", value, 16'h1234);
    scan(16'h5959, 4'b0100, 4'b0000, 0);
    chk("t4_value", value, 16'h5959);
    chk("t4_dp", dp, 4'b0100);
    chk("t4_model_dp", e_dp, 4'b0100);

    // 5: scan stops, then resumes
    drive(4'hF, 8'hFF, TIMEOUT + 100);
    chk("t5_link_lost", link_lost, 1'b1);
    chk("t5_valid_dropped", value_valid, 1'b0);
    chk("t5_value_kept", value, 16'h5959);
    drive(4'b0111, {1'b1, code_tab[5]}, 20);
    chk("t5_link_back", link_lost, 1'b0);
    drive(4'b0111, {1'b1, code_tab[5]}, 30);
    drive(4'b1011, {1'b0, code_tab[9]}, 50);
    drive(4'b1101, {1'b1, code_tab[5]}, 50);
    drive(4'b1110, {1'b1, code_tab[9]}, 50);
    chk("t5_valid_after_1", value_valid, 1'b0);
    scan(16'h5959, 4'b0100, 4'b0000, 0);
    chk("t5_valid_after_2", value_valid, 1'b1);

    // 6: reset after two digits captured
    drive(4'b0111, {1'b1, code_tab[1]}, 50);
    drive(4'b1011, {1'b1, code_tab[2]}, 50);
    drive(4'b1101, {1'b1, code_tab[3]}, 10);
    reset_p = 1'b1;
    #1;
    chk("t6_reset_outputs", {value, dp, value_valid, frame_pulse, decode_err, link_lost}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset_p = 1'b0;
    n_fp = 0;
    drive(4'b1101, {1'b1, code_tab[3]}, 40);
    drive(4'b1110, {1'b1, code_tab[4]}, 50);
    chk("t6_no_partial_frame", n_fp, 0);
    scan(16'h1234, 4'b0000, 4'b0000, 0);
    chk("t6_first_frame", n_fp, 1);
    chk("t6_valid_after_1", value_valid, 1'b0);
    scan(16'h1234, 4'b0000, 4'b0000, 0);
    chk("t6_value", value, 16'h1234);
    chk("t6_valid", value_valid, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
